// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: state_t FSM encoding, ZERO_REG (x0 address), ctrl_t bundle of
// stage-register enables and flushes, plus the fixed control patterns.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    LUSTALL = 2'd3
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  // Bit order follows ctrl_t: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush.
  localparam ctrl_t CTRL_GO     = ctrl_t'(7'b11111_00);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b00000_00);
  localparam ctrl_t CTRL_INIT   = ctrl_t'(7'b00000_11);
  localparam ctrl_t CTRL_MISP   = ctrl_t'(7'b11111_11);
  // Hold PC and IF/ID, push a bubble into ID/EX, let older stages drain.
  localparam ctrl_t CTRL_LU     = ctrl_t'(7'b00111_01);

endpackage

// File: rtl/hazard_loaduse_det.sv
// Combinational load-use comparator: ID source operands vs a pending load's rd.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output is a plain hit flag.
//
// Ports: rs1_addr_i/rs2_addr_i + use_rs1_i/use_rs2_i (consumer operands),
//        memread_i + rd_addr_i (producer), hit_o (stall required).
module hazard_loaduse_det
  import hazard_pkg::*;
(
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  input  logic       memread_i,
  input  logic [4:0] rd_addr_i,
  output logic       hit_o
);

  logic rs1_match;
  logic rs2_match;

  // Operands the instruction does not actually read must not create a hazard.
  assign rs1_match = use_rs1_i && (rs1_addr_i == rd_addr_i);
  assign rs2_match = use_rs2_i && (rs2_addr_i == rd_addr_i);

  // x0 is hardwired zero, so a load targeting it never produces a dependency.
  assign hit_o = memread_i && (rd_addr_i != ZERO_REG) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, flushes and PC redirect for
// load-use, mispredict and data-memory wait hazards (RV32I 5-stage).
// Latency: decisions are combinational and take effect in the same cycle.
// Backpressure: dmem not ready freezes every stage register until dmem_ready.
//
// Ports: ID operand info, EX load/rd/mispredict, MEM request/ready in;
//        five stage enables, two flushes, pc_redirect, sticky mem_timeout_err,
//        state_o (debug) out.
// Optional: define HAZARD_PERF_EN to add the CNT_W-bit counters
//        perf_lu_stalls, perf_flushes and perf_mem_wait.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_addr_id,
  input  logic [4:0] rs2_addr_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic       memread_ex,
  input  logic [4:0] rd_addr_ex,
  input  logic       mispredict_ex,
  input  logic       dmem_req_mem,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pc_redirect,
  output logic       mem_timeout_err,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_lu_stalls,
  output logic [CNT_W-1:0] perf_flushes,
  output logic [CNT_W-1:0] perf_mem_wait
`endif
);

  localparam int unsigned WD_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q;
  logic            tmo_hit;
  logic            mem_stall;
  logic            lu_hit;
  ctrl_t           ctrl;

  hazard_loaduse_det u_lu_det (
    .rs1_addr_i (rs1_addr_id),
    .rs2_addr_i (rs2_addr_id),
    .use_rs1_i  (use_rs1_id),
    .use_rs2_i  (use_rs2_id),
    .memread_i  (memread_ex),
    .rd_addr_i  (rd_addr_ex),
    .hit_o      (lu_hit)
  );

  assign mem_stall = dmem_req_mem && !dmem_ready;

  always_comb begin
    state_d     = state_q;
    ctrl        = CTRL_INIT;
    pc_redirect = 1'b0;
    wd_d        = '0;
    tmo_hit     = 1'b0;
    unique case (state_q)
      INIT: begin
        state_d = RUN;
      end
      RUN: begin
        if (mem_stall) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEMWAIT;
        end else if (mispredict_ex) begin
          // Wrong-path ID instruction: any load-use hit on it is irrelevant.
          ctrl        = CTRL_MISP;
          pc_redirect = 1'b1;
        end else if (lu_hit) begin
          ctrl    = CTRL_LU;
          state_d = LUSTALL;
        end else begin
          ctrl = CTRL_GO;
        end
      end
      LUSTALL: begin
        // EX holds the bubble, so neither load-use nor mispredict can fire.
        if (mem_stall) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEMWAIT;
        end else begin
          ctrl    = CTRL_GO;
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (dmem_ready) begin
          ctrl    = CTRL_GO;
          state_d = RUN;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wd_q == WD_MAX) begin
            tmo_hit = 1'b1;
            wd_d    = wd_q;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_q | tmo_hit;
    end
  end

  // The error is visible in the cycle the watchdog expires, then held.
  assign mem_timeout_err = err_q | tmo_hit;

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign idex_en    = ctrl.idex_en;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign state_o    = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_lu_q, perf_fl_q, perf_mw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q <= '0;
      perf_fl_q <= '0;
      perf_mw_q <= '0;
    end else begin
      if (state_q == RUN && state_d == LUSTALL) perf_lu_q <= perf_lu_q + CNT_W'(1);
      if (state_q == RUN && pc_redirect)        perf_fl_q <= perf_fl_q + CNT_W'(1);
      if (state_q == MEMWAIT)                   perf_mw_q <= perf_mw_q + CNT_W'(1);
    end
  end

  assign perf_lu_stalls = perf_lu_q;
  assign perf_flushes   = perf_fl_q;
  assign perf_mem_wait  = perf_mw_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// Outputs are sampled on the falling clock edge.
module tb_hazard_ctrl;

  localparam int TMO = 4;

  // Output vector order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, redirect.
  localparam logic [7:0] V_GO     = 8'b11111_000;
  localparam logic [7:0] V_FREEZE = 8'b00000_000;
  localparam logic [7:0] V_INIT   = 8'b00000_110;
  localparam logic [7:0] V_MISP   = 8'b11111_111;
  localparam logic [7:0] V_LU     = 8'b00111_010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] rs1_addr_id = '0, rs2_addr_id = '0, rd_addr_ex = '0;
  logic       use_rs1_id = 0, use_rs2_id = 0, memread_ex = 0;
  logic       mispredict_ex = 0, dmem_req_mem = 0, dmem_ready = 0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, pc_redirect, mem_timeout_err;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_stalls, perf_flushes, perf_mem_wait;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .memread_ex(memread_ex), .rd_addr_ex(rd_addr_ex),
    .mispredict_ex(mispredict_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pc_redirect(pc_redirect), .mem_timeout_err(mem_timeout_err),
    .state_o(state_o)
`ifdef HAZARD_PERF_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes),
    .perf_mem_wait(perf_mem_wait)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] outv;
  assign outv = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, pc_redirect};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The pipeline is in exactly one "mode": just out of reset, frozen on
  // memory, one bubble already inserted, or free running.
  bit m_init = 1, m_frozen = 0, m_bubble = 0, m_err = 0;
  int m_wait = 0;
  bit n_init, n_frozen, n_bubble, n_err;
  int n_wait;
`ifdef HAZARD_PERF_EN
  int unsigned m_lu = 0, m_fl = 0, m_mw = 0;
  int unsigned n_lu, n_fl, n_mw;
`endif

  always @(negedge clk) begin
    logic [7:0] ev;
    logic [1:0] es;
    logic       ee;
    bit         stall, lu;
    n_init = 0; n_frozen = m_frozen; n_bubble = 0; n_err = m_err; n_wait = 0;
`ifdef HAZARD_PERF_EN
    n_lu = m_lu; n_fl = m_fl; n_mw = m_mw;
`endif
    stall = dmem_req_mem && !dmem_ready;
    lu = memread_ex && rd_addr_ex != 0 &&
         ((use_rs1_id && rs1_addr_id == rd_addr_ex) ||
          (use_rs2_id && rs2_addr_id == rd_addr_ex));
    ee = m_err;
    if (!rst_n || m_init) begin
      ev = V_INIT; es = 2'd0; ee = !rst_n ? 1'b0 : m_err;
    end else if (m_frozen) begin
      es = 2'd2;
`ifdef HAZARD_PERF_EN
      n_mw = m_mw + 1;
`endif
      if (dmem_ready) begin
        ev = V_GO; n_frozen = 0;
      end else begin
        ev = V_FREEZE;
        n_wait = m_wait + 1;
        if (m_wait >= TMO - 1) begin ee = 1'b1; n_err = 1; end
      end
    end else if (m_bubble) begin
      es = 2'd3;
      if (stall) begin ev = V_FREEZE; n_frozen = 1; end
      else ev = V_GO;
    end else begin
      es = 2'd1;
      if (stall) begin
        ev = V_FREEZE; n_frozen = 1;
      end else if (mispredict_ex) begin
        ev = V_MISP;
`ifdef HAZARD_PERF_EN
        n_fl = m_fl + 1;
`endif
      end else if (lu) begin
        ev = V_LU; n_bubble = 1;
`ifdef HAZARD_PERF_EN
        n_lu = m_lu + 1;
`endif
      end else begin
        ev = V_GO;
      end
    end
    chk("cyc_ctrl", {24'd0, outv}, {24'd0, ev});
    chk("cyc_state", {30'd0, state_o}, {30'd0, es});
    chk("cyc_err", {31'd0, mem_timeout_err}, {31'd0, ee});
`ifdef HAZARD_PERF_EN
    if (!rst_n) begin
      chk("cyc_perf_rst", perf_lu_stalls | perf_flushes | perf_mem_wait, 32'd0);
    end else begin
      chk("cyc_perf_lu", perf_lu_stalls, m_lu);
      chk("cyc_perf_fl", perf_flushes, m_fl);
      chk("cyc_perf_mw", perf_mem_wait, m_mw);
    end
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init <= 1; m_frozen <= 0; m_bubble <= 0; m_err <= 0; m_wait <= 0;
`ifdef HAZARD_PERF_EN
      m_lu <= 0; m_fl <= 0; m_mw <= 0;
`endif
    end else begin
      m_init <= n_init; m_frozen <= n_frozen; m_bubble <= n_bubble;
      m_err <= n_err; m_wait <= n_wait;
`ifdef HAZARD_PERF_EN
      m_lu <= n_lu; m_fl <= n_fl; m_mw <= n_mw;
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic mr,
                     input logic [4:0] rd, input logic mp,
                     input logic rq, input logic rdy);
    @(posedge clk);
    #1;
    rs1_addr_id = r1; rs2_addr_id = r2; use_rs1_id = u1; use_rs2_id = u2;
    memread_ex = mr; rd_addr_ex = rd; mispredict_ex = mp;
    dmem_req_mem = rq; dmem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic lit(input string name, input logic [7:0] v, input logic [1:0] s);
    chk({name, "_ctrl"}, {24'd0, outv}, {24'd0, v});
    chk({name, "_state"}, {30'd0, state_o}, {30'd0, s});
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    lit("reset", V_INIT, 2'd0);
    chk("reset_err", {31'd0, mem_timeout_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    lit("init_cycle", V_INIT, 2'd0);
    idle();                                   lit("first_run", V_GO, 2'd1);

    // load-use on rs2
    drv(5'd0, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0);  lit("lu_hit", V_LU, 2'd1);
    idle();                                   lit("lu_bubble", V_GO, 2'd3);
    idle();                                   lit("lu_back", V_GO, 2'd1);

    // x0 and unused operand filters
    drv(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0);  lit("x0_filter", V_GO, 2'd1);
    drv(5'd7, 5'd0, 0, 0, 1, 5'd7, 0, 0, 0);  lit("unused_rs1", V_GO, 2'd1);

    // mispredict overrides load-use
    drv(5'd0, 5'd5, 0, 1, 1, 5'd5, 1, 0, 0);  lit("misp_lu", V_MISP, 2'd1);
    idle();                                   lit("misp_after", V_GO, 2'd1);

    // three-cycle memory wait
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);  lit("mw1", V_FREEZE, 2'd1);
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);  lit("mw2", V_FREEZE, 2'd2);
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);  lit("mw3", V_FREEZE, 2'd2);
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);  lit("mw_ready", V_GO, 2'd2);
    idle();                                   lit("mw_run", V_GO, 2'd1);
    chk("mw_no_err", {31'd0, mem_timeout_err}, 32'd0);

    // watchdog: error on the 4th MEMWAIT cycle, sticky afterwards
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
      chk("wd_err", {31'd0, mem_timeout_err}, (k >= 4) ? 32'd1 : 32'd0);
    end
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);  lit("wd_release", V_GO, 2'd2);
    idle();
    chk("wd_sticky", {31'd0, mem_timeout_err}, 32'd1);

    // reset in the middle of MEMWAIT
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);  lit("pre_rst", V_FREEZE, 2'd2);
    #2 rst_n = 0;
    #1;
    lit("mid_rst", V_INIT, 2'd0);
    chk("mid_rst_err", {31'd0, mem_timeout_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1; dmem_req_mem = 0; dmem_ready = 0;
    @(negedge clk);
    lit("rst_init", V_INIT, 2'd0);
`ifdef HAZARD_PERF_EN
    chk("rst_perf", perf_lu_stalls | perf_flushes | perf_mem_wait, 32'd0);
`endif
    idle();                                   lit("rst_run", V_GO, 2'd1);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n         = ($urandom_range(0, 199) != 0);
      rs1_addr_id   = 5'($urandom_range(0, 7));
      rs2_addr_id   = 5'($urandom_range(0, 7));
      rd_addr_ex    = 5'($urandom_range(0, 7));
      use_rs1_id    = 1'($urandom_range(0, 1));
      use_rs2_id    = 1'($urandom_range(0, 1));
      memread_ex    = 1'($urandom_range(0, 1));
      mispredict_ex = ($urandom_range(0, 7) == 0);
      dmem_req_mem  = ($urandom_range(0, 2) != 0);
      dmem_ready    = ($urandom_range(0, 3) != 0);
      if ((i % 97) < 6) dmem_ready = 0;
    end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
